// File: rtl/bin_to_bcd_sequencer_if.sv
// Handshake and data bundle between a binary source and the BCD sequencer.
// master drives the operand and start strobe; slave returns status and result.
interface bin_to_bcd_sequencer_if #(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = 4
);
    logic [BIN_W-1:0]    bin_in;
    logic                start;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd_out;
    logic                overflow;

    modport master (
        output bin_in,
        output start,
        input  busy,
        input  done,
        input  bcd_out,
        input  overflow
    );

    modport slave (
        input  bin_in,
        input  start,
        output busy,
        output done,
        output bcd_out,
        output overflow
    );
endinterface

// File: rtl/bin_to_bcd_sequencer.sv
// Iterative binary-to-packed-BCD converter (double dabble, one bit every two
// cycles) feeding a 4-digit seven-segment display. The result register only
// changes on the done edge, so downstream logic never sees partial values.
// Inputs above MAX_VAL saturate to all-9 digits and raise overflow.
//
// Optional build macro AUTO_CONVERT_EN: when defined, an idle block starts a
// conversion by itself whenever bin_in differs from the last accepted value.
module bin_to_bcd_sequencer #(
    parameter int unsigned BIN_W   = 14,
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned MAX_VAL = 9999
) (
    input  logic                  clk,
    input  logic                  reset,
    bin_to_bcd_sequencer_if.slave bus
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam logic [BCD_W-1:0] SAT_VAL = {DIGITS{4'h9}};

    typedef enum logic [1:0] {
        StIdle,
        StAdjust,
        StShift,
        StFinish
    } state_e;

    state_e            state;
    logic [BIN_W-1:0]  shreg;
    logic [BCD_W-1:0]  scratch;
    logic [CNT_W-1:0]  cnt;
    logic              ovf_pend;
    logic              busy;
    logic              done;
    logic [BCD_W-1:0]  bcd;
    logic              overflow;
    logic              accept;
    logic              over_max;

    // Add 3 to every nibble that is 5 or more; nibbles never carry into each other.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        r = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign over_max = 32'(bus.bin_in) > MAX_VAL;

`ifdef AUTO_CONVERT_EN
    logic [BIN_W-1:0] last_bin;

    // An idle block treats a changed operand exactly like an explicit start.
    assign accept = bus.start || (bus.bin_in != last_bin);

    // Remember the operand taken at each accept edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_bin <= '0;
        end else if (state == StIdle && accept) begin
            last_bin <= bus.bin_in;
        end
    end
`else
    assign accept = bus.start;
`endif

    // Conversion sequencer with registered status and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StIdle;
            shreg    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (accept) begin
                        shreg    <= bus.bin_in;
                        scratch  <= '0;
                        cnt      <= CNT_W'(BIN_W);
                        ovf_pend <= over_max;
                        busy     <= 1'b1;
                        state    <= StAdjust;
                    end
                end
                StAdjust: begin
                    scratch <= add3(scratch);
                    state   <= StShift;
                end
                StShift: begin
                    scratch <= {scratch[BCD_W-2:0], shreg[BIN_W-1]};
                    shreg   <= shreg << 1;
                    cnt     <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        // busy drops entering FINISH so it never overlaps done.
                        busy  <= 1'b0;
                        state <= StFinish;
                    end else begin
                        state <= StAdjust;
                    end
                end
                StFinish: begin
                    bcd      <= ovf_pend ? SAT_VAL : scratch;
                    overflow <= ovf_pend;
                    done     <= 1'b1;
                    state    <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.bcd_out  = bcd;
    assign bus.overflow = overflow;
endmodule
